mem_bus_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the shared data-memory port in the multicore CPU.

---
 rtl/mem_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared data-memory port.
// One transaction at a time: reads take 4 cycles, writes take 3.
module mem_bus_arbiter #(
   parameter int NUM_CORES  = 4,
   parameter int MEM_WIDTH  = 12,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_CORES-1:0]            req,
   input  logic [NUM_CORES-1:0]            we,
   input  logic [NUM_CORES*ADDR_WIDTH-1:0] addr,
   input  logic [NUM_CORES*MEM_WIDTH-1:0]  wdata,
   output logic [NUM_CORES-1:0]            gnt,
   output logic [NUM_CORES-1:0]            done,
   output logic [MEM_WIDTH-1:0]            rdata,
   output logic                            busy,
   output logic                            mem_en,
   output logic                            mem_we,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   output logic [MEM_WIDTH-1:0]            mem_wdata,
   input  logic [MEM_WIDTH-1:0]            mem_rdata
);

   localparam int IW = $clog2(NUM_CORES);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RDWAIT,
      DONE
   } state_e;

   state_e               state_q, state_d;
   logic [IW-1:0]        g_q, g_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   logic                 wr_q, wr_d;
   logic [NUM_CORES-1:0] gnt_q, gnt_d;
   logic [MEM_WIDTH-1:0] rdata_q, rdata_d;

   logic [IW-1:0]        sel;
   logic [IW-1:0]        cand;
   logic                 sel_vld;

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
      if (v == IW'(NUM_CORES-1)) begin
         return '0;
      end
      return v + 1'b1;
   endfunction

   // First requester at or above ptr, wrapping past the last core.
   always_comb begin
      sel     = ptr_q;
      sel_vld = 1'b0;
      cand    = ptr_q;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (!sel_vld && req[cand]) begin
            sel     = cand;
            sel_vld = 1'b1;
         end
         cand = wrap_inc(cand);
      end
   end

   always_comb begin
      state_d   = state_q;
      g_d       = g_q;
      ptr_d     = ptr_q;
      wr_d      = wr_q;
      gnt_d     = gnt_q;
      rdata_d   = rdata_q;
      done      = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (state_q)
         IDLE: begin
            if (sel_vld) begin
               g_d        = sel;
               wr_d       = we[sel];
               gnt_d      = '0;
               gnt_d[sel] = 1'b1;
               state_d    = ACCESS;
            end
         end
         ACCESS: begin
            // Address and data come live from the granted core.
            mem_en    = 1'b1;
            mem_we    = wr_q;
            mem_addr  = addr[int'(g_q)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata = wdata[int'(g_q)*MEM_WIDTH +: MEM_WIDTH];
            state_d   = wr_q ? DONE : RDWAIT;
         end
         RDWAIT: begin
            rdata_d = mem_rdata;
            state_d = DONE;
         end
         DONE: begin
            done    = gnt_q;
            gnt_d   = '0;
            ptr_d   = wrap_inc(g_q);
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         g_q     <= '0;
         ptr_q   <= '0;
         wr_q    <= 1'b0;
         gnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
         wr_q    <= wr_d;
         gnt_q   <= gnt_d;
         rdata_q <= rdata_d;
      end
   end

   assign gnt   = gnt_q;
   assign rdata = rdata_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model with its own memory image.
module tb_mem_bus_arbiter;

   localparam int N  = 4;
   localparam int MW = 12;
   localparam int AW = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req, we;
   logic [N*AW-1:0] addr;
   logic [N*MW-1:0] wdata;
   logic [N-1:0]    gnt, done;
   logic [MW-1:0]   rdata;
   logic            busy, mem_en, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [MW-1:0]   mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   mem_bus_arbiter #(
      .NUM_CORES (N),
      .MEM_WIDTH (MW),
      .ADDR_WIDTH(AW)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
      .gnt      (gnt),
      .done     (done),
      .rdata    (rdata),
      .busy     (busy),
      .mem_en   (mem_en),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Synchronous RAM seen by the DUT; preload port used only during reset.
   logic [MW-1:0] mem [256];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [MW-1:0] pl_data = '0;

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   // Reference model: one transaction in flight, t counts its cycles.
   logic [MW-1:0] ref_mem [256];
   bit            m_act;
   bit            m_wr;
   int            m_g, m_t, m_ptr;
   logic [MW-1:0] m_rdata, m_pend;
   int            grant_log[$];
   logic [N-1:0]  drop_mask;
   int            n_checks = 0;
   int            n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_len();
      return m_wr ? 2 : 3;
   endfunction

   function automatic int winner();
      for (int k = 0; k < N; k++)
         if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_gnt();
      logic [N-1:0] v;
      v = '0;
      if (m_act) v[m_g] = 1'b1;
      return v;
   endfunction

   function automatic logic [N-1:0] exp_done();
      return (m_act && m_t == m_len()) ? exp_gnt() : '0;
   endfunction

   task automatic model_reset();
      m_act   = 0;
      m_ptr   = 0;
      m_t     = 0;
      m_rdata = '0;
   endtask

   // Advance the model by one clock using the inputs of the elapsed cycle.
   task automatic model_update();
      logic [AW-1:0] a;
      if (m_act) begin
         if (m_t == 1) begin
            a = addr[m_g*AW +: AW];
            if (m_wr) ref_mem[a] = wdata[m_g*MW +: MW];
            else      m_pend = ref_mem[a];
         end
         if (m_t == 2 && !m_wr) m_rdata = m_pend;
         if (m_t == m_len()) begin
            m_act = 0;
            m_ptr = (m_g + 1) % N;
         end else begin
            m_t++;
         end
      end else if (|req) begin
         m_g   = winner();
         m_wr  = we[m_g];
         m_act = 1;
         m_t   = 1;
         grant_log.push_back(m_g);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_update();
   endtask

   task automatic chk_outs();
      bit acc;
      #1;
      acc = m_act && m_t == 1;
      check("gnt", gnt, exp_gnt());
      check("done", done, exp_done());
      check("busy", busy, m_act);
      check("mem_en", mem_en, acc);
      check("mem_we", mem_we, acc && m_wr);
      check("mem_addr", mem_addr, acc ? addr[m_g*AW +: AW] : '0);
      check("mem_wdata", mem_wdata, acc ? wdata[m_g*MW +: MW] : '0);
      check("rdata", rdata, m_rdata);
      check("gnt_onehot", $onehot0(gnt), 1);
      check("done_onehot", $onehot0(done), 1);
   endtask

   task automatic cyc();
      tick();
      req = req & ~(exp_done() & drop_mask);
      chk_outs();
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 20 && m_act; k++) cyc();
      check("idle_reached", busy, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_grants(input int n, input int budget);
      for (int k = 0; k < budget && grant_log.size() < n; k++) cyc();
   endtask

   function automatic int log_at(input int k);
      return (grant_log.size() > k) ? grant_log[k] : -1;
   endfunction

   initial begin
      rst_n     = 1'b0;
      req       = '1;
      we        = '0;
      addr      = '0;
      wdata     = '0;
      drop_mask = '1;
      model_reset();

      // Reset held with all requests up; also preload memory.
      for (int i = 0; i < 256; i++) begin
         pl_en      = 1'b1;
         pl_addr    = AW'(i);
         pl_data    = (i == 'h3C) ? 12'hA5F : MW'($urandom);
         ref_mem[i] = pl_data;
         @(posedge clk);
         #1;
         if (i < 3) begin
            check("rst_gnt", gnt, 0);
            check("rst_done", done, 0);
            check("rst_mem_en", mem_en, 0);
            check("rst_busy", busy, 0);
         end
      end
      pl_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      check("rst_first_gnt", gnt, 4'b0001);
      // Request dropped while granted: the read still completes.
      req = '0;
      wait_idle();

      // Single read by core 2.
      addr[2*AW +: AW] = 8'h3C;
      req = 4'b0100;
      cyc();
      check("rd_mem_en", mem_en, 1);
      check("rd_mem_addr", mem_addr, 8'h3C);
      cyc();
      cyc();
      check("rd_done", done, 4'b0100);
      check("rd_rdata", rdata, 12'hA5F);
      wait_idle();

      // Single write by core 1.
      we                 = 4'b0010;
      addr[1*AW +: AW]   = 8'h10;
      wdata[1*MW +: MW]  = 12'h123;
      req                = 4'b0010;
      cyc();
      check("wr_mem_en", mem_en, 1);
      check("wr_mem_we", mem_we, 1);
      check("wr_mem_addr", mem_addr, 8'h10);
      check("wr_mem_wdata", mem_wdata, 12'h123);
      we = '0;
      cyc();
      check("wr_done", done, 4'b0010);
      check("wr_rdata_keep", rdata, 12'hA5F);
      wait_idle();

      // Read the written word back through core 0.
      addr[0 +: AW] = 8'h10;
      req = 4'b0001;
      cyc();
      cyc();
      cyc();
      check("rb_rdata", rdata, 12'h123);
      wait_idle();

      // Round robin from a fresh pointer.
      do_reset();
      grant_log.delete();
      req = 4'b1111;
      run_grants(4, 60);
      wait_idle();
      for (int k = 0; k < 4; k++) check("rr_order", log_at(k), k);
      grant_log.delete();
      req = 4'b1001;
      run_grants(2, 30);
      wait_idle();
      check("rr_1001_first", log_at(0), 0);
      check("rr_1001_second", log_at(1), 3);

      // Core 0 keeps requesting; core 3 must still get its turn.
      grant_log.delete();
      drop_mask = 4'b1000;
      req = 4'b1001;
      run_grants(3, 40);
      check("starve_0", log_at(0), 0);
      check("starve_1", log_at(1), 3);
      check("starve_2", log_at(2), 0);
      req = '0;
      drop_mask = '1;
      wait_idle();

      // Reset during a core 1 read aborts it.
      req = 4'b0010;
      cyc();
      cyc();
      req = 4'b1010;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("abort_gnt", gnt, 0);
      check("abort_done", done, 0);
      check("abort_busy", busy, 0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("abort_no_done", done, 0);
         check("abort_no_en", mem_en, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      check("abort_ptr0_gnt", gnt, 4'b0010);
      req = '0;
      wait_idle();

      // Random traffic on a small address window.
      for (int c = 0; c < 3000; c++) begin
         logic [N-1:0] dn;
         tick();
         dn = exp_done();
         for (int i = 0; i < N; i++) begin
            if (dn[i] && $urandom_range(3) != 0) begin
               req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(2) == 0) begin
               req[i]              = 1'b1;
               we[i]               = 1'($urandom_range(1));
               addr[i*AW +: AW]    = AW'($urandom_range(15));
               wdata[i*MW +: MW]   = MW'($urandom);
            end else if ($urandom_range(7) == 0) begin
               we[i]               = 1'($urandom_range(1));
               addr[i*AW +: AW]    = AW'($urandom_range(15));
               wdata[i*MW +: MW]   = MW'($urandom);
            end
            if (req[i] && $urandom_range(63) == 0) req[i] = 1'b0;
         end
         chk_outs();
      end
      req = '0;
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
